// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, x/y raster counters and registered
// sync/blanking decodes that change on the same edge as the coordinates.
module vga_sync_gen #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pixel_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0] div_cnt;
  logic       tick_cond;
  logic       div_wrap;
  logic       x_last;
  logic       y_last;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;

  // Out-of-range counter values are treated as "last" so they fall back to 0
  // on the next step instead of running away.
  always_comb begin
    tick_cond = (div_cnt == DIV_LAST);
    div_wrap  = tick_cond || (div_cnt > DIV_LAST);
    x_last    = (x >= H_LAST);
    y_last    = (y >= V_LAST);
    x_nxt     = x;
    y_nxt     = y;
    if (tick_cond) begin
      if (x_last) begin
        x_nxt = 10'd0;
        y_nxt = y_last ? 10'd0 : y + 10'd1;
      end else begin
        x_nxt = x + 10'd1;
      end
    end
  end

  // Decodes look at the next-state coordinates so controls and x/y share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= 4'd0;
      pixel_tick  <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      video_on    <= 1'b1;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_wrap ? 4'd0 : div_cnt + 4'd1;
      pixel_tick  <= tick_cond;
      x           <= x_nxt;
      y           <= y_nxt;
      video_on    <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
      hsync       <= ((x_nxt >= HS_BEG) && (x_nxt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync       <= ((y_nxt >= VS_BEG) && (y_nxt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
      frame_start <= tick_cond && x_last && y_last;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: standard timing, a CLK_DIV=1 build and a shrunken
// raster, all checked each cycle against an arithmetic raster model.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       fs;
  } out_t;

  typedef struct {
    int   cyc;
    out_t exp;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;      // clock edges since last reset release
  bit chk_on = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  // DUT instances
  logic       tick_a, von_a, hs_a, vs_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       tick_b, von_b, hs_b, vs_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       tick_c, von_c, hs_c, vs_c, fs_c;
  logic [9:0] x_c, y_c;
  out_t oa, ob, oc;
  assign oa = {tick_a, x_a, y_a, von_a, hs_a, vs_a, fs_a};
  assign ob = {tick_b, x_b, y_b, von_b, hs_b, vs_b, fs_b};
  assign oc = {tick_c, x_c, y_c, von_c, hs_c, vs_c, fs_c};

  vga_sync_gen u_dut (
    .clk(clk), .rst_n(rst_n), .pixel_tick(tick_a), .x(x_a), .y(y_a),
    .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
  );

  vga_sync_gen #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .pixel_tick(tick_b), .x(x_b), .y(y_b),
    .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pixel_tick(tick_c), .x(x_c), .y(y_c),
    .video_on(von_c), .hsync(hs_c), .vsync(vs_c), .frame_start(fs_c)
  );

  // reference model: pixel index from elapsed clocks, then raster position
  function automatic out_t model(int cyc, int div, int ha, int hfp, int hsw, int hbp,
                                 int va, int vfp, int vsw, int vbp, bit pol);
    out_t o;
    int ht, vt, p, xx, yy;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    p  = cyc / div;
    xx = p % ht;
    yy = (p / ht) % vt;
    o.tick = (cyc > 0) && (cyc % div == 0);
    o.x    = 10'(xx);
    o.y    = 10'(yy);
    o.von  = (xx < ha) && (yy < va);
    o.hs   = (xx >= ha + hfp && xx < ha + hfp + hsw) ? pol : !pol;
    o.vs   = (yy >= va + vfp && yy < va + vfp + vsw) ? pol : !pol;
    o.fs   = o.tick && (p % (ht * vt) == 0);
    return o;
  endfunction

  // scoreboard
  task automatic check(input string name, input out_t got, input out_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s n=%0d got tick=%0b x=%0d y=%0d von=%0b hs=%0b vs=%0b fs=%0b exp tick=%0b x=%0d y=%0d von=%0b hs=%0b vs=%0b fs=%0b",
               name, n, got.tick, got.x, got.y, got.von, got.hs, got.vs, got.fs,
               exp.tick, exp.x, exp.y, exp.von, exp.hs, exp.vs, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_std",   oa, model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      check("model_div1",  ob, model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      check("model_small", oc, model(n, 3, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1));
    end
  end

  // driver tasks
  task automatic wait_n(input int target);
    int g = 0;
    while (n < target && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (n != target) check_int("wait_n_timeout", n, target);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic vec_t mk(int c, bit t, int xx, int yy, bit v, bit h, bit vs, bit f);
    vec_t r;
    r.cyc = c;
    r.exp = {t, 10'(xx), 10'(yy), v, h, vs, f};
    return r;
  endfunction

  vec_t vecs[13];
  localparam out_t RST_EXP = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int hs_low, ticks, g, n0, vs_cnt, b_ticks, off;

    vecs[0]  = mk(0,    0, 0,   0, 1, 1, 1, 0);
    vecs[1]  = mk(1,    0, 0,   0, 1, 1, 1, 0);
    vecs[2]  = mk(2,    1, 1,   0, 1, 1, 1, 0);
    vecs[3]  = mk(3,    0, 1,   0, 1, 1, 1, 0);
    vecs[4]  = mk(1279, 0, 639, 0, 1, 1, 1, 0);
    vecs[5]  = mk(1280, 1, 640, 0, 0, 1, 1, 0);
    vecs[6]  = mk(1311, 0, 655, 0, 0, 1, 1, 0);
    vecs[7]  = mk(1312, 1, 656, 0, 0, 0, 1, 0);
    vecs[8]  = mk(1503, 0, 751, 0, 0, 0, 1, 0);
    vecs[9]  = mk(1504, 1, 752, 0, 0, 1, 1, 0);
    vecs[10] = mk(1599, 0, 799, 0, 0, 1, 1, 0);
    vecs[11] = mk(1600, 1, 0,   1, 1, 1, 1, 0);
    vecs[12] = mk(1601, 0, 0,   1, 1, 1, 1, 0);

    repeat (3) @(posedge clk);
    #2 check("reset_state", oa, RST_EXP);
    chk_on = 1'b1;
    release_reset();

    for (int i = 0; i < 13; i++) begin
      wait_n(vecs[i].cyc);
      check($sformatf("vec%0d", i), oa, vecs[i].exp);
    end

    // one full line (y=1): hsync low for exactly 96 pixel ticks
    hs_low = 0;
    ticks  = 0;
    g      = 0;
    while (n < 3200 && g < 4000) begin
      @(negedge clk);
      g++;
      if (tick_a) begin
        ticks++;
        if (!hs_a) hs_low++;
      end
    end
    check_int("line_ticks", ticks, 800);
    check_int("line_hsync_low", hs_low, 96);
    check_int("line_end_y", int'(y_a), 2);

    // mid-frame asynchronous reset
    g = 0;
    while (!(x_a == 10'd300 && y_a == 10'd2) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check_int("reach_300_2", int'(x_a) * 1000 + int'(y_a), 300002);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", oa, RST_EXP);
    repeat (3) @(posedge clk);
    #2 check("reset_hold", oa, RST_EXP);
    rst_n = 1'b1;
    wait_n(2);
    check("restart_x1", oa, mk(2, 1, 1, 0, 1, 1, 1, 0).exp);

    // small raster: frame period, vsync width, CLK_DIV=1 tick density
    g = 0;
    while (!fs_c && g < 2000) begin
      @(negedge clk);
      g++;
    end
    n0 = n;
    check_int("small_first_fs", n0, 360);
    vs_cnt  = 0;
    b_ticks = 0;
    g       = 0;
    do begin
      @(negedge clk);
      g++;
      if (tick_c && vs_c) vs_cnt++;
      if (tick_b) b_ticks++;
    end while (!fs_c && g < 2000);
    check_int("small_frame_period", n - n0, 360);
    check_int("small_vsync_ticks", vs_cnt, 30);
    check_int("div1_tick_count", b_ticks, 360);

    // randomized reset pulses at random in-cycle offsets
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(1, 1200)) @(posedge clk);
      off = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) off += 5;
      #(off) rst_n = 1'b0;
      #1 check("rand_async_reset", oa, RST_EXP);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #2 rst_n = 1'b1;
    end
    repeat (1000) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
